alu_multicycle: RTL and testbench

- Parametrised, handshaked successor to the single-cycle datapath ALU.
- Keeps the existing 4-bit operation encoding, adds SUB, iterative MUL/MULHU and unsigned DIVU/REMU, and registers every result behind a valid/ready output.
- Sits between register-file read and writeback. The control unit stalls on in_ready/out_valid instead of assuming single-cycle completion.

---
 rtl/alu_multicycle_if.sv | 28 ++
 rtl/alu_multicycle.sv | 110 +++++++++++
 tb/tb_alu_multicycle.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_multicycle_if.sv
// Operand/result handshake bundle for alu_multicycle.
// The slave side is the ALU; the master side is the control unit.
`timescale 1ns/1ps
interface alu_multicycle_if #(
  parameter int REG_WIDTH = 32
);
  logic                 in_valid;
  logic                 in_ready;
  logic [REG_WIDTH-1:0] in1;
  logic [REG_WIDTH-1:0] in2;
  logic [3:0]           alu_control;
  logic                 out_valid;
  logic                 out_ready;
  logic [REG_WIDTH-1:0] result;
  logic                 zero;
  logic                 sign;
  logic                 busy;

  modport slave (
    input  in_valid, in1, in2, alu_control, out_ready,
    output in_ready, out_valid, result, zero, sign, busy
  );

  modport master (
    output in_valid, in1, in2, alu_control, out_ready,
    input  in_ready, out_valid, result, zero, sign, busy
  );
endinterface

// File: rtl/alu_multicycle.sv
// Handshaked ALU: single-cycle logic/add/shift, iterative MUL/MULHU and
// restoring DIVU/REMU taking REG_WIDTH steps, result held until consumed.
`timescale 1ns/1ps
module alu_multicycle #(
  parameter int REG_WIDTH = 32,
  parameter int SHAMT_W   = $clog2(REG_WIDTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  alu_multicycle_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t               state_q, state_d;
  logic [REG_WIDTH-1:0] hi_q, lo_q, b_q, result_q;
  logic [REG_WIDTH-1:0] hi_d, lo_d, quick_res, multi_res;
  logic [SHAMT_W-1:0]   cnt_q, shamt;
  logic [3:0]           op_q;
  logic                 accept, is_multi, last_iter;
  logic [REG_WIDTH:0]   mul_sum, rem_sh;
  logic [REG_WIDTH-1:0] rem_sub;
  logic                 rem_ge;

  assign accept    = bus.in_valid && (state_q == IDLE) && !flush;
  // MUL 0100, MULHU 0101, DIVU 1100, REMU 1101 are exactly the codes with [2:1]==10
  assign is_multi  = (bus.alu_control[2:1] == 2'b10);
  assign last_iter = (cnt_q == SHAMT_W'(REG_WIDTH - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = is_multi ? BUSY : DONE;
      BUSY:    if (last_iter) state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  always_comb begin
    shamt = bus.in2[SHAMT_W-1:0];
    case (bus.alu_control)
      4'b0000: quick_res = bus.in1 & bus.in2;
      4'b0001: quick_res = bus.in1 | bus.in2;
      4'b0011: quick_res = bus.in1 ^ bus.in2;
      4'b0110: quick_res = bus.in1 - bus.in2;
      4'b1000: quick_res = bus.in1 << shamt;
      4'b1010: quick_res = bus.in1 >> shamt;
      4'b1011: quick_res = $signed(bus.in1) >>> shamt;
      default: quick_res = bus.in1 + bus.in2;
    endcase
  end

  // hi:lo is the product accumulator (multiply) or remainder:quotient (divide)
  always_comb begin
    mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    rem_sh  = {hi_q, lo_q[REG_WIDTH-1]};
    rem_ge  = (rem_sh >= {1'b0, b_q});
    rem_sub = rem_sh[REG_WIDTH-1:0] - b_q;
    if (op_q[3]) begin
      hi_d = rem_ge ? rem_sub : rem_sh[REG_WIDTH-1:0];
      lo_d = {lo_q[REG_WIDTH-2:0], rem_ge};
    end else begin
      hi_d = mul_sum[REG_WIDTH:1];
      lo_d = {mul_sum[0], lo_q[REG_WIDTH-1:1]};
    end
    multi_res = op_q[0] ? hi_d : lo_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hi_q     <= '0;
      lo_q     <= '0;
      b_q      <= '0;
      op_q     <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else if (accept) begin
      op_q  <= bus.alu_control;
      cnt_q <= '0;
      if (is_multi) begin
        hi_q <= '0;
        lo_q <= bus.alu_control[3] ? bus.in1 : bus.in2;
        b_q  <= bus.alu_control[3] ? bus.in2 : bus.in1;
      end else begin
        result_q <= quick_res;
      end
    end else if (state_q == BUSY && !flush) begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      cnt_q <= cnt_q + SHAMT_W'(1);
      if (last_iter) result_q <= multi_res;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q == BUSY);
  assign bus.result    = result_q;
  assign bus.zero      = (result_q == '0);
  assign bus.sign      = result_q[REG_WIDTH-1];

endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle: directed vector table, randomized
// operations against an arithmetic reference model, and abort/backpressure sequences.
`timescale 1ns/1ps
module tb_alu_multicycle;

  logic clk, reset_n, flush;
  int   tests, fails;

  alu_multicycle_if #(.REG_WIDTH(32)) bus ();

  alu_multicycle #(.REG_WIDTH(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (flush),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0]  code;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    longint unsigned p;
    int unsigned     sh;
    p  = longint'(a) * longint'(b);
    sh = b % 32;
    case (c)
      4'h0: return a & b;
      4'h1: return a | b;
      4'h3: return a ^ b;
      4'h6: return a - b;
      4'h8: return a << sh;
      4'hA: return a >> sh;
      4'hB: return $signed(a) >>> sh;
      4'h4: return p[31:0];
      4'h5: return p[63:32];
      4'hC: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      4'hD: return (b == 0) ? a : a % b;
      default: return a + b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [3:0] c);
    return (c inside {4'h4, 4'h5, 4'hC, 4'hD}) ? 33 : 1;
  endfunction

  // Called just after a negedge with the DUT idle and out_ready high.
  task automatic run_op(input string tag, input logic [3:0] code, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int lat, busy_n, rdy_n;
    bus.in_valid    = 1'b1;
    bus.alu_control = code;
    bus.in1         = a;
    bus.in2         = b;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid    = 1'b0;
    bus.in1         = $urandom;
    bus.in2         = $urandom;
    bus.alu_control = 4'($urandom);
    lat = 1; busy_n = 0; rdy_n = 0;
    while (!bus.out_valid && lat < 100) begin
      busy_n += int'(bus.busy);
      rdy_n  += int'(bus.in_ready);
      @(negedge clk);
      lat++;
    end
    check({tag, " result"}, bus.result, exp);
    check({tag, " zero"}, 32'(bus.zero), 32'(exp == 0));
    check({tag, " sign"}, 32'(bus.sign), 32'(exp[31]));
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " busy_cycles"}, busy_n, exp_lat - 1);
    check({tag, " in_ready_while_pending"}, rdy_n, 0);
    @(posedge clk);
    @(negedge clk);
    check({tag, " out_valid_after_xfer"}, 32'(bus.out_valid), 0);
    check({tag, " in_ready_after_xfer"}, 32'(bus.in_ready), 1);
  endtask

  initial begin
    logic [3:0]  c;
    logic [31:0] a, b;
    int          seen, waited;
    tests = 0;
    fails = 0;

    vecs[0]  = '{4'h2, 32'hFFFF_FFFF, 32'h1,         32'h0,         1};
    vecs[1]  = '{4'hB, 32'h8000_0000, 32'h24,        32'hF800_0000, 1};
    vecs[2]  = '{4'h8, 32'h8000_0000, 32'h24,        32'h0,         1};
    vecs[3]  = '{4'h4, 32'hFFFF_FFFF, 32'h2,         32'hFFFF_FFFE, 33};
    vecs[4]  = '{4'h5, 32'hFFFF_FFFF, 32'h2,         32'h1,         33};
    vecs[5]  = '{4'hC, 32'd100,       32'd7,         32'd14,        33};
    vecs[6]  = '{4'hD, 32'd100,       32'd7,         32'd2,         33};
    vecs[7]  = '{4'hC, 32'h1234_5678, 32'h0,         32'hFFFF_FFFF, 33};
    vecs[8]  = '{4'hD, 32'h1234_5678, 32'h0,         32'h1234_5678, 33};
    vecs[9]  = '{4'h0, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h00F0_000F, 1};
    vecs[10] = '{4'h1, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'hFFF0_0FFF, 1};
    vecs[11] = '{4'h3, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'hFF00_0FF0, 1};
    vecs[12] = '{4'h6, 32'd5,         32'd7,         32'hFFFF_FFFE, 1};
    vecs[13] = '{4'hA, 32'h8000_0000, 32'h21,        32'h4000_0000, 1};
    vecs[14] = '{4'h7, 32'd3,         32'd4,         32'd7,         1};
    vecs[15] = '{4'hF, 32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 1};
    vecs[16] = '{4'h5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};

    reset_n         = 1'b0;
    flush           = 1'b0;
    bus.in_valid    = 1'b0;
    bus.out_ready   = 1'b1;
    bus.in1         = '0;
    bus.in2         = '0;
    bus.alu_control = '0;
    repeat (3) @(negedge clk);
    check("reset in_ready", 32'(bus.in_ready), 1);
    check("reset out_valid", 32'(bus.out_valid), 0);
    check("reset result", bus.result, 0);
    check("reset zero", 32'(bus.zero), 1);
    check("reset sign", 32'(bus.sign), 0);
    check("reset busy", 32'(bus.busy), 0);
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 17; i++)
      run_op($sformatf("vec%0d", i), vecs[i].code, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);

    // Backpressure: result held while consumer stalls and inputs wiggle
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.alu_control = 4'h4; bus.in1 = 32'd3; bus.in2 = 32'd5;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    waited = 0;
    while (!bus.out_valid && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check("bp out_valid", 32'(bus.out_valid), 1);
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = 1'b1; bus.alu_control = 4'h2;
      bus.in1 = $urandom; bus.in2 = $urandom;
      @(negedge clk);
      check($sformatf("bp hold result %0d", i), bus.result, 32'd15);
      check($sformatf("bp hold in_ready %0d", i), 32'(bus.in_ready), 0);
      check($sformatf("bp hold out_valid %0d", i), 32'(bus.out_valid), 1);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("bp after xfer out_valid", 32'(bus.out_valid), 0);
    check("bp after xfer in_ready", 32'(bus.in_ready), 1);
    check("bp after xfer busy", 32'(bus.busy), 0);
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("bp single transfer", 32'(bus.out_valid), 0);

    // Flush at busy iteration 5
    bus.in_valid = 1'b1; bus.alu_control = 4'hC; bus.in1 = 32'd1000; bus.in2 = 32'd3;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("flush pre busy", 32'(bus.busy), 1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush in_ready", 32'(bus.in_ready), 1);
    check("flush busy", 32'(bus.busy), 0);
    check("flush out_valid", 32'(bus.out_valid), 0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      seen += int'(bus.out_valid);
    end
    check("flush no late result", seen, 0);

    // Flush coincident with in_valid must not accept
    bus.in_valid = 1'b1; bus.alu_control = 4'h2; bus.in1 = 32'd9; bus.in2 = 32'd9;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    bus.in_valid = 1'b0;
    check("flush+valid out_valid", 32'(bus.out_valid), 0);
    check("flush+valid busy", 32'(bus.busy), 0);
    check("flush+valid in_ready", 32'(bus.in_ready), 1);
    @(negedge clk);
    check("flush+valid no late", 32'(bus.out_valid), 0);

    // Reset at iteration 10 of a DIVU
    run_op("pre-reset add", 4'h2, 32'd1, 32'd2, 32'd3, 1);
    bus.in_valid = 1'b1; bus.alu_control = 4'hC; bus.in1 = 32'd1000; bus.in2 = 32'd3;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (9) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("midreset result", bus.result, 0);
    check("midreset zero", 32'(bus.zero), 1);
    check("midreset sign", 32'(bus.sign), 0);
    check("midreset out_valid", 32'(bus.out_valid), 0);
    check("midreset in_ready", 32'(bus.in_ready), 1);
    check("midreset busy", 32'(bus.busy), 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    run_op("post-reset add", 4'h2, 32'h10, 32'h20, 32'h30, 1);

    // Randomized operations against the reference model
    for (int i = 0; i < 40; i++) begin
      c = 4'($urandom_range(0, 15));
      a = $urandom;
      case (i % 4)
        0:       b = 32'h0;
        1:       b = $urandom_range(1, 300);
        default: b = $urandom;
      endcase
      run_op($sformatf("rand%0d op%h", i, c), c, a, b, ref_op(c, a, b), ref_lat(c));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
